// File: rtl/leaderboard_scoring_pkg.sv
// Shared types and helpers for the leaderboard scoring engine.
package scoring_pkg;

  typedef enum logic [2:0] {
    INIT, IDLE, FETCH, CATCH, COMPARE, WRITE, RANK, DONE
  } state_t;

  function automatic int unsigned rank_w(input int unsigned topk);
    return $clog2(topk + 1);
  endfunction

  // Double-dabble digit correction: add 3 to any digit of 5 or more before shifting.
  function automatic logic [3:0] bcd_adjust(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/leaderboard_scoring_if.sv
// Score submission / result handshake between access controller and scoring engine.
interface leaderboard_scoring_if #(
  parameter int ID_W    = 5,
  parameter int SCORE_W = 7,
  parameter int RANK_W  = 2
);
  logic               req_valid;
  logic               req_ready;
  logic [ID_W-1:0]    player_id;
  logic [SCORE_W-1:0] score;
  logic               result_valid;
  logic               result_pbest;
  logic               result_global;
  logic [RANK_W-1:0]  result_rank;
  logic [ID_W-1:0]    gwinner;

  modport master (
    output req_valid, player_id, score,
    input  req_ready, result_valid, result_pbest, result_global, result_rank, gwinner
  );

  modport slave (
    input  req_valid, player_id, score,
    output req_ready, result_valid, result_pbest, result_global, result_rank, gwinner
  );
endinterface

// File: rtl/leaderboard_scoring_bcd.sv
// Combinational binary-to-BCD converter (double dabble), units digit in [3:0].
module score_bcd
  import scoring_pkg::*;
#(
  parameter int SCORE_W = 7,
  parameter int DIGITS  = 3
) (
  input  logic [SCORE_W-1:0]  bin,
  output logic [4*DIGITS-1:0] bcd
);

  logic [4*DIGITS-1:0] acc;

  always_comb begin
    acc = '0;
    for (int unsigned k = 0; k < SCORE_W; k++) begin
      for (int unsigned d = 0; d < DIGITS; d++) begin
        acc[4*d +: 4] = bcd_adjust(acc[4*d +: 4]);
      end
      acc = {acc[4*DIGITS-2:0], bin[SCORE_W-1-k]};
    end
    bcd = acc;
  end

endmodule

// File: rtl/leaderboard_scoring.sv
// Scoring engine: personal bests in external RAM, sorted top-K board on chip.
module leaderboard_scoring
  import scoring_pkg::*;
#(
  parameter  int NPLAYERS = 32,
  parameter  int SCORE_W  = 7,
  parameter  int GUEST_ID = 3,
  parameter  int TOPK     = 3,
  parameter  int RAM_LAT  = 3,
  parameter  int DIGITS   = 3,
  localparam int ID_W     = $clog2(NPLAYERS),
  localparam int RANK_W   = rank_w(TOPK)
) (
  input  logic                clk,
  input  logic                rst,
  leaderboard_scoring_if.slave bus,
  output logic [ID_W-1:0]     ram_addr,
  output logic                ram_we,
  output logic [SCORE_W-1:0]  ram_wdata,
  input  logic [SCORE_W-1:0]  ram_rdata,
  input  logic [RANK_W-1:0]   lb_sel,
  output logic [ID_W-1:0]     lb_id,
  output logic [SCORE_W-1:0]  lb_score,
  output logic                lb_valid,
  output logic [4*DIGITS-1:0] bcd_out
);

  localparam int CNT_W = $clog2(RAM_LAT + 1);

  typedef struct packed {
    logic               valid;
    logic [ID_W-1:0]    id;
    logic [SCORE_W-1:0] score;
  } lb_entry_t;

  lb_entry_t          lb     [TOPK];
  lb_entry_t          lb_nxt [TOPK];
  state_t             state;
  logic [ID_W-1:0]    cur_id;
  logic [SCORE_W-1:0] cur_score;
  logic [SCORE_W-1:0] stored;
  logic               cur_guest;
  logic               pbest_r;
  logic [RANK_W-1:0]  rank_r;
  logic [CNT_W-1:0]   cnt;
  logic [RANK_W-1:0]  ins_p;
  logic [RANK_W-1:0]  own_j;
  logic [RANK_W-1:0]  shift_end;

  score_bcd #(.SCORE_W(SCORE_W), .DIGITS(DIGITS)) u_bcd (
    .bin (cur_score),
    .bcd (bcd_out)
  );

  // Insertion point p, the player's own slot j (non-guest only), then shift p..end down by one.
  always_comb begin
    ins_p = RANK_W'(TOPK);
    own_j = RANK_W'(TOPK);
    for (int unsigned k = 0; k < TOPK; k++) begin
      if (!lb[TOPK-1-k].valid || lb[TOPK-1-k].score < cur_score) ins_p = RANK_W'(TOPK-1-k);
      if (!cur_guest && lb[TOPK-1-k].valid && lb[TOPK-1-k].id == cur_id) own_j = RANK_W'(TOPK-1-k);
    end
    shift_end = (own_j < RANK_W'(TOPK)) ? own_j : RANK_W'(TOPK-1);
    for (int unsigned i = 0; i < TOPK; i++) begin
      lb_nxt[i] = lb[i];
      if (RANK_W'(i) == ins_p)
        lb_nxt[i] = '{valid: 1'b1, id: cur_id, score: cur_score};
      else if (RANK_W'(i) > ins_p && RANK_W'(i) <= shift_end)
        lb_nxt[i] = lb[(i > 0) ? i - 1 : 0];
    end
  end

  always_comb begin
    lb_valid = 1'b0;
    lb_id    = '0;
    lb_score = '0;
    if (lb_sel < RANK_W'(TOPK)) begin
      lb_valid = lb[lb_sel].valid;
      lb_id    = lb[lb_sel].id;
      lb_score = lb[lb_sel].score;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= INIT;
      ram_addr          <= '0;
      ram_we            <= 1'b1;
      ram_wdata         <= '0;
      bus.req_ready     <= 1'b0;
      bus.result_valid  <= 1'b0;
      bus.result_pbest  <= 1'b0;
      bus.result_global <= 1'b0;
      bus.result_rank   <= '0;
      bus.gwinner       <= '0;
      cur_id            <= '0;
      cur_score         <= '0;
      cur_guest         <= 1'b0;
      stored            <= '0;
      pbest_r           <= 1'b0;
      rank_r            <= '0;
      cnt               <= '0;
      for (int unsigned i = 0; i < TOPK; i++) lb[i] <= '0;
    end else begin
      bus.result_valid <= 1'b0;
      case (state)
        INIT: begin
          if (ram_addr == ID_W'(NPLAYERS - 1)) begin
            ram_we        <= 1'b0;
            ram_addr      <= '0;
            bus.req_ready <= 1'b1;
            state         <= IDLE;
          end else begin
            ram_addr <= ram_addr + 1'b1;
          end
        end
        IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            bus.req_ready <= 1'b0;
            cur_id        <= bus.player_id;
            cur_score     <= bus.score;
            cur_guest     <= (bus.player_id == ID_W'(GUEST_ID));
            cnt           <= '0;
            if (bus.player_id == ID_W'(GUEST_ID)) begin
              pbest_r <= 1'b0;
              state   <= RANK;
            end else begin
              ram_addr <= bus.player_id;
              ram_we   <= 1'b0;
              state    <= FETCH;
            end
          end
        end
        FETCH: begin
          if (cnt == CNT_W'(RAM_LAT - 1)) state <= CATCH;
          else cnt <= cnt + 1'b1;
        end
        CATCH: begin
          stored <= ram_rdata;
          state  <= COMPARE;
        end
        COMPARE: begin
          cnt <= '0;
          if (cur_score > stored) begin
            pbest_r   <= 1'b1;
            ram_we    <= 1'b1;
            ram_wdata <= cur_score;
            state     <= WRITE;
          end else begin
            pbest_r <= 1'b0;
            rank_r  <= RANK_W'(TOPK);
            state   <= DONE;
          end
        end
        WRITE: begin
          if (cnt == CNT_W'(RAM_LAT - 1)) begin
            ram_we    <= 1'b0;
            ram_wdata <= '0;
            state     <= RANK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RANK: begin
          for (int unsigned i = 0; i < TOPK; i++) lb[i] <= lb_nxt[i];
          rank_r <= ins_p;
          state  <= DONE;
        end
        DONE: begin
          bus.result_valid  <= 1'b1;
          bus.result_pbest  <= pbest_r;
          bus.result_rank   <= rank_r;
          bus.result_global <= (rank_r == '0);
          bus.gwinner       <= (rank_r == '0) ? cur_id : '0;
          bus.req_ready     <= 1'b1;
          state             <= IDLE;
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_leaderboard_scoring.sv
// Directed bench for leaderboard_scoring: RAM model, PB/leaderboard model and result scoreboard.
`timescale 1ns/100ps
module tb_leaderboard_scoring;
  localparam int NP = 32, SW = 7, GUEST = 3, TOPK = 3, LAT = 3, DIG = 3, IDW = 5, RW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  leaderboard_scoring_if #(.ID_W(IDW), .SCORE_W(SW), .RANK_W(RW)) bus ();

  logic [IDW-1:0]   ram_addr;
  logic             ram_we;
  logic [SW-1:0]    ram_wdata;
  logic [SW-1:0]    ram_rdata;
  logic [RW-1:0]    lb_sel;
  logic [IDW-1:0]   lb_id;
  logic [SW-1:0]    lb_score;
  logic             lb_valid;
  logic [4*DIG-1:0] bcd_out;

  leaderboard_scoring #(
    .NPLAYERS(NP), .SCORE_W(SW), .GUEST_ID(GUEST), .TOPK(TOPK), .RAM_LAT(LAT), .DIGITS(DIG)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .lb_sel(lb_sel), .lb_id(lb_id), .lb_score(lb_score), .lb_valid(lb_valid),
    .bcd_out(bcd_out)
  );

  // Single-port RAM with LAT-cycle read latency.
  logic [SW-1:0] mem     [NP];
  logic [SW-1:0] rd_pipe [LAT];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    rd_pipe[0] <= mem[ram_addr];
    for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign ram_rdata = rd_pipe[LAT-1];

  int n_assert = 0;
  int n_fail   = 0;

  int pb   [NP];
  int m_id [TOPK];
  int m_sc [TOPK];
  bit m_v  [TOPK];

  typedef struct {int pbest; int glob; int rank; int gw; int lat;} exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int bcd_of(input int sc);
    return ((sc / 100) << 8) | (((sc / 10) % 10) << 4) | (sc % 10);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NP; i++) pb[i] = 0;
    for (int i = 0; i < TOPK; i++) begin m_v[i] = 0; m_id[i] = 0; m_sc[i] = 0; end
  endtask

  // Rebuild the board as a list: drop the player's old entry, insert below equal scores, truncate.
  function automatic int lb_insert(input int id, input int sc);
    int tid[$];
    int tsc[$];
    int pos;
    for (int i = 0; i < TOPK; i++)
      if (m_v[i] && (id == GUEST || m_id[i] != id)) begin tid.push_back(m_id[i]); tsc.push_back(m_sc[i]); end
    pos = 0;
    while (pos < tsc.size() && tsc[pos] >= sc) pos++;
    tid.insert(pos, id);
    tsc.insert(pos, sc);
    for (int i = 0; i < TOPK; i++) begin
      m_v[i]  = (i < tsc.size());
      m_id[i] = m_v[i] ? tid[i] : 0;
      m_sc[i] = m_v[i] ? tsc[i] : 0;
    end
    return (pos < TOPK) ? pos : TOPK;
  endfunction

  task automatic wait_ready(input int limit);
    int n;
    n = 0;
    while (!bus.req_ready && n < limit) begin @(posedge clk); #1; n++; end
    chk("ready_wait", bus.req_ready, 1);
  endtask

  task automatic submit(input int id, input int sc);
    exp_t e;
    exp_t got;
    int   cyc;
    e.pbest = 0;
    e.rank  = TOPK;
    if (id == GUEST) begin
      e.lat = 2; e.rank = lb_insert(id, sc);
    end else if (sc > pb[id]) begin
      e.pbest = 1; e.lat = 2*LAT + 4; pb[id] = sc; e.rank = lb_insert(id, sc);
    end else begin
      e.lat = LAT + 3;
    end
    e.glob = (e.rank == 0) ? 1 : 0;
    e.gw   = e.glob ? id : 0;
    sb.push_back(e);
    wait_ready(200);
    bus.req_valid = 1'b1; bus.player_id = IDW'(id); bus.score = SW'(sc);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("bcd", bcd_out, bcd_of(sc));
    cyc = 0;
    do begin @(posedge clk); #1; cyc++; end while (!bus.result_valid && cyc < 60);
    got = sb.pop_front();
    chk("latency", cyc, got.lat);
    chk("pbest", bus.result_pbest, got.pbest);
    chk("global", bus.result_global, got.glob);
    chk("rank", bus.result_rank, got.rank);
    chk("gwinner", bus.gwinner, got.gw);
    chk("ram_pb", mem[id], pb[id]);
  endtask

  task automatic chk_board_model();
    @(negedge clk);
    for (int i = 0; i <= TOPK; i++) begin
      lb_sel = RW'(i); #1;
      if (i < TOPK) begin
        chk("lb_valid", lb_valid, m_v[i]);
        chk("lb_id", lb_id, m_id[i]);
        chk("lb_score", lb_score, m_sc[i]);
      end else begin
        chk("lb_oob", {lb_valid, lb_id, lb_score}, 0);
      end
    end
    lb_sel = '0;
  endtask

  task automatic chk_entry(input int i, input int id, input int sc);
    @(negedge clk);
    lb_sel = RW'(i); #1;
    chk("entry_valid", lb_valid, 1);
    chk("entry_id", lb_id, id);
    chk("entry_score", lb_score, sc);
    lb_sel = '0;
  endtask

  initial begin
    int writes, ready_cyc, pulses;
    bus.req_valid = 1'b0; bus.player_id = '0; bus.score = '0; lb_sel = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_result_valid", bus.result_valid, 0);
    chk("rst_lb_valid", lb_valid, 0);
    chk("rst_bcd", bcd_out, 0);
    chk("rst_gwinner", bus.gwinner, 0);
    chk("rst_ram_we", ram_we, 1);
    rst = 1'b0;

    // INIT sweep; a request raised mid-INIT must be ignored.
    writes = 0; ready_cyc = 0; pulses = 0;
    for (int c = 1; c <= 40; c++) begin
      bus.req_valid = (c >= 3 && c <= 6); bus.player_id = 5'd7; bus.score = 7'd99;
      if (bus.req_ready) begin ready_cyc = c; break; end
      if (ram_we && ram_wdata == '0 && int'(ram_addr) == writes) writes++;
      if (bus.result_valid) pulses++;
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    chk("init_writes", writes, NP);
    chk("init_ready_cycle", ready_cyc, NP + 1);
    repeat (5) begin @(posedge clk); #1; if (bus.result_valid) pulses++; end
    chk("init_req_ignored", pulses, 0);
    chk("init_bcd_unchanged", bcd_out, 0);
    chk("init_ram_we_low", ram_we, 0);

    submit(5, 40);
    submit(5, 30);
    chk_board_model();
    submit(1, 50);
    submit(2, 50);
    submit(5, 45);
    chk_entry(0, 1, 50); chk_entry(1, 2, 50); chk_entry(2, 5, 45);
    submit(5, 55);
    chk_entry(0, 5, 55); chk_entry(1, 1, 50); chk_entry(2, 2, 50);
    submit(GUEST, 60);
    submit(GUEST, 60);
    chk_board_model();
    submit(1, 90);
    submit(2, 80);
    submit(4, 70);
    submit(6, 10);
    chk_entry(0, 1, 90); chk_entry(1, 2, 80); chk_entry(2, 4, 70);
    submit(7, 127);
    chk("bcd_127", bcd_out, 12'h127);
    chk_board_model();

    // Abort a personal-best write with rst; INIT must wipe the partial write.
    wait_ready(200);
    bus.req_valid = 1'b1; bus.player_id = 5'd9; bus.score = 7'd100;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (LAT + 3) @(posedge clk);
    #1;
    chk("in_write_we", ram_we, 1);
    chk("in_write_addr", ram_addr, 9);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_req_ready", bus.req_ready, 0);
    chk("abort_result_valid", bus.result_valid, 0);
    chk("abort_pbest", bus.result_pbest, 0);
    chk("abort_rank", bus.result_rank, 0);
    chk("abort_gwinner", bus.gwinner, 0);
    chk("abort_bcd", bcd_out, 0);
    chk("abort_lb_valid", lb_valid, 0);
    chk("abort_ram_addr", ram_addr, 0);
    rst = 1'b0;
    model_reset();
    wait_ready(60);
    chk("abort_ram9_cleared", mem[9], 0);
    chk("abort_ram5_cleared", mem[5], 0);
    submit(9, 20);
    chk_board_model();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
